// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register load controller: FSM states,
// op codes and the counter width helper.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_PRESET = 1'b1;

    // Bit-position counter width; at least one bit even for tiny widths.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the load controller: synchronous clear-to-zero,
// count enable, and a terminal flag when the count reaches WIDTH-1.
module shift_bit_counter
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 6,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_load_ctrl.sv
// Sequences a parallel word (or an all-ones preset) into a shift-left register,
// MSB first, then pulses done. Optional readback check: SHIFT_CTRL_VERIFY_EN.
module shift_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_sin,
    output logic             sr_ld,
    output logic             busy,
    output logic             done
`ifdef SHIFT_CTRL_VERIFY_EN
    ,
    output logic             error
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    // Mask selecting bit WIDTH-2; shifted right by cnt it picks the next bit to send.
    localparam logic [WIDTH-1:0] SEL_BASE = WIDTH'(1) << (WIDTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expect_q, expect_d;
    logic             op_q, op_d;
    logic             sr_sin_q, sr_sin_d;
    logic             sr_ld_q, sr_ld_d;
    logic             cnt_clr, cnt_en, cnt_term;
    logic [CNT_W-1:0] cnt;
    logic             next_bit;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk_i  (clk),
        .rst_i  (clear),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .term_o (cnt_term)
    );

    assign next_bit = |(expect_q & (SEL_BASE >> cnt));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            expect_q <= '0;
            op_q     <= OP_LOAD;
            sr_sin_q <= 1'b0;
            sr_ld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            op_q     <= op_d;
            sr_sin_q <= sr_sin_d;
            sr_ld_q  <= sr_ld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_term) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        expect_d = expect_q;
        op_d     = op_q;
        sr_sin_d = 1'b0;
        sr_ld_d  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    expect_d = (op == OP_PRESET) ? '1 : data;
                    op_d     = op;
                    cnt_clr  = 1'b1;
                    sr_sin_d = (op == OP_PRESET) ? 1'b0 : data[WIDTH-1];
                    sr_ld_d  = op;
                end
            end
            ST_SHIFT: begin
                // Last shift edge: stop the counter so it never wraps, idle the lines.
                if (!cnt_term) begin
                    cnt_en   = 1'b1;
                    sr_sin_d = (op_q == OP_PRESET) ? 1'b0 : next_bit;
                    sr_ld_d  = op_q;
                end
            end
            default: ;
        endcase
    end

    assign sr_sin = sr_sin_q;
    assign sr_ld  = sr_ld_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

`ifdef SHIFT_CTRL_VERIFY_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (state_q == ST_IDLE && start) begin
            error_d = 1'b0;
        end else if (state_q == ST_DONE && sr_q != expect_q) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic sr_q_unused;
    assign sr_q_unused = ^sr_q;
`endif

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed bench for shift_load_ctrl with a behavioural shift-left register
// (sync load-ones on ld, async clear) attached; error checks under SHIFT_CTRL_VERIFY_EN.
module tb_shift_load_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] sr_q_model;
    logic [W-1:0] fault_mask = '0;
    logic [W-1:0] sr_q;
    logic         sr_sin, sr_ld, busy, done;
`ifdef SHIFT_CTRL_VERIFY_EN
    logic         error;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sr_q = sr_q_model & ~fault_mask;

    always_ff @(posedge clk or posedge clear) begin
        if (clear)      sr_q_model <= '0;
        else if (sr_ld) sr_q_model <= '1;
        else            sr_q_model <= {sr_q_model[W-2:0], sr_sin};
    end

    shift_load_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .data   (data),
        .sr_q   (sr_q),
        .sr_sin (sr_sin),
        .sr_ld  (sr_ld),
        .busy   (busy),
        .done   (done)
`ifdef SHIFT_CTRL_VERIFY_EN
        ,
        .error  (error)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to done (bounded); poke_at>0 re-strobes start mid-SHIFT.
    task automatic run_cmd(input logic op_v, input logic [W-1:0] data_v,
                           input int poke_at, input logic [W-1:0] poke_data,
                           output int lat, output int ld_cyc, output int sin_ones,
                           output int busy_cyc);
        ld_cyc = 0; sin_ones = 0; busy_cyc = 0;
        op = op_v; data = data_v; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            ld_cyc += int'(sr_ld); sin_ones += int'(sr_sin); busy_cyc += int'(busy);
            if (lat == poke_at) begin
                start = 1'b1;
                data  = poke_data;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        ld_cyc += int'(sr_ld); sin_ones += int'(sr_sin); busy_cyc += int'(busy);
        $display("cmd op=%0d data=%b -> latency=%0d sr_q=%b ld_cycles=%0d busy_cycles=%0d",
                 op_v, data_v, lat, sr_q, ld_cyc, busy_cyc);
    endtask

    initial begin
        int lat, ldc, sinc, bc, dones, first_done, second_done;

        // Reset state
        tick(); tick();
        check("rst_sin", 32'(sr_sin), 0);
        check("rst_ld", 32'(sr_ld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
`ifdef SHIFT_CTRL_VERIFY_EN
        check("rst_error", 32'(error), 0);
`endif
        clear = 1'b0;
        tick();

        // 1. Plain load
        run_cmd(1'b0, 6'b101100, 0, '0, lat, ldc, sinc, bc);
        check("t1_latency", 32'(lat), 7);
        check("t1_sr_q", 32'(sr_q), 32'b101100);
        check("t1_ld_cycles", 32'(ldc), 0);
        check("t1_busy_cycles", 32'(bc), 7);
        tick();
        check("t1_done_drop", 32'(done), 0);
        check("t1_busy_drop", 32'(busy), 0);

        // 2. Preset fill
        run_cmd(1'b1, 6'b000000, 0, '0, lat, ldc, sinc, bc);
        check("t2_latency", 32'(lat), 7);
        check("t2_sr_q", 32'(sr_q), 32'b111111);
        check("t2_ld_cycles", 32'(ldc), 6);
        check("t2_sin_ones", 32'(sinc), 0);
        tick();

        // 3. Start during SHIFT is ignored
        run_cmd(1'b0, 6'b010101, 3, 6'b111000, lat, ldc, sinc, bc);
        check("t3_latency", 32'(lat), 7);
        check("t3_sr_q", 32'(sr_q), 32'b010101);
        check("t3_busy_cycles", 32'(bc), 7);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            dones += int'(done);
        end
        check("t3_extra_done", 32'(dones), 0);

        // 4. Clear after three shift edges
        op = 1'b0; data = 6'b110011; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t4_partial_q", 32'(sr_q), 32'b000110);
        clear = 1'b1;
        #1;
        check("t4_clr_q", 32'(sr_q), 0);
        check("t4_clr_busy", 32'(busy), 0);
        check("t4_clr_done", 32'(done), 0);
        tick();
        clear = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(done);
        end
        check("t4_no_done", 32'(dones), 0);
        run_cmd(1'b0, 6'b100001, 0, '0, lat, ldc, sinc, bc);
        check("t4_latency", 32'(lat), 7);
        check("t4_sr_q", 32'(sr_q), 32'b100001);
        tick();

        // 5. start held high: one command every WIDTH+2 cycles
        first_done = -1; second_done = -1;
        op = 1'b0; data = 6'b011010; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done) begin
                check("t5_sr_q", 32'(sr_q), 32'b011010);
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        $display("back-to-back data=011010 -> done at edges %0d and %0d", first_done, second_done);
        check("t5_first_done", 32'(first_done), 6);
        check("t5_gap", 32'(second_done - first_done), 8);
        tick();
        check("t5_idle", 32'(busy), 0);

`ifdef SHIFT_CTRL_VERIFY_EN
        // 6. Readback mismatch sets error until the next accepted start
        op = 1'b0; data = 6'b111111; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("t6_latency", 32'(lat), 7);
        check("t6_error_in_done", 32'(error), 0);
        fault_mask = 6'b000100;
        tick();
        fault_mask = '0;
        check("t6_error_set", 32'(error), 1);
        tick(); tick();
        check("t6_error_held", 32'(error), 1);
        run_cmd(1'b0, 6'b111111, 0, '0, lat, ldc, sinc, bc);
        check("t6_clean_sr_q", 32'(sr_q), 32'b111111);
        check("t6_error_cleared", 32'(error), 0);
        tick();
        check("t6_error_stays_low", 32'(error), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
